// File: rtl/iopmp_tlul_reg_if_if.sv
// TL-UL A/D channel bundle plus the register-file side of the IOPMP reg adapter.
// master = TL host / register file view, slave = the adapter itself.
interface iopmp_tlul_reg_if_if #(
  parameter int AddrWidth   = 12,
  parameter int SourceWidth = 8
);
  logic                   a_valid;
  logic [2:0]             a_opcode;
  logic [1:0]             a_size;
  logic [SourceWidth-1:0] a_source;
  logic [AddrWidth-1:0]   a_address;
  logic [3:0]             a_mask;
  logic [31:0]            a_data;
  logic                   a_ready;

  logic                   d_valid;
  logic [2:0]             d_opcode;
  logic [1:0]             d_size;
  logic [SourceWidth-1:0] d_source;
  logic [31:0]            d_data;
  logic                   d_error;
  logic                   d_ready;

  logic                   reg_we;
  logic                   reg_re;
  logic [AddrWidth-1:0]   reg_addr;
  logic [31:0]            reg_wdata;
  logic [31:0]            reg_rdata;
  logic                   reg_error;

  modport slave (
    input  a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    output a_ready,
    output d_valid, d_opcode, d_size, d_source, d_data, d_error,
    input  d_ready,
    output reg_we, reg_re, reg_addr, reg_wdata,
    input  reg_rdata, reg_error
  );

  modport master (
    output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data,
    input  a_ready,
    input  d_valid, d_opcode, d_size, d_source, d_data, d_error,
    output d_ready,
    input  reg_we, reg_re, reg_addr, reg_wdata,
    output reg_rdata, reg_error
  );
endinterface

// File: rtl/iopmp_tlul_reg_if.sv
// TL-UL to register-strobe adapter, one transaction in flight: accept N, strobe N+1, D valid N+2.
// Backpressure: a_ready only in IDLE; a stalled d_ready holds the response and blocks new requests.
module iopmp_tlul_reg_if #(
  parameter int AddrWidth   = 12,
  parameter int SourceWidth = 8
) (
  input logic              clk,
  input logic              rst,
  iopmp_tlul_reg_if_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             size;
    logic [SourceWidth-1:0] source;
    logic [AddrWidth-1:0]   address;
    logic [3:0]             mask;
    logic [31:0]            data;
  } req_t;

  localparam logic [2:0] OpPutFull       = 3'd0;
  localparam logic [2:0] OpPutPartial    = 3'd1;
  localparam logic [2:0] OpGet           = 3'd4;
  localparam logic [2:0] OpAccessAck     = 3'd0;
  localparam logic [2:0] OpAccessAckData = 3'd1;

  function automatic logic f_is_put(input req_t r);
    return (r.opcode == OpPutFull) || (r.opcode == OpPutPartial);
  endfunction

  // Registers are word-wide only, so sub-word Puts are rejected rather than merged.
  function automatic logic f_illegal(input req_t r);
    logic bad_op;
    bad_op = !(f_is_put(r) || (r.opcode == OpGet));
    return bad_op || (r.size != 2'd2) || (r.address[1:0] != 2'b00) ||
           (f_is_put(r) && (r.mask != 4'hF));
  endfunction

  state_t                 r_state;
  req_t                   r_req;
  logic                   r_a_ready;
  logic                   r_reg_we;
  logic                   r_reg_re;
  logic                   r_d_valid;
  logic [2:0]             r_d_opcode;
  logic [1:0]             r_d_size;
  logic [SourceWidth-1:0] r_d_source;
  logic [31:0]            r_d_data;
  logic                   r_d_error;

  req_t                   w_a_req;
  logic                   w_a_illegal;
  logic                   w_req_illegal;
  logic                   w_acc_error;

  always_comb begin
    w_a_req         = '0;
    w_a_req.opcode  = bus.a_opcode;
    w_a_req.size    = bus.a_size;
    w_a_req.source  = bus.a_source;
    w_a_req.address = bus.a_address;
    w_a_req.mask    = bus.a_mask;
    w_a_req.data    = bus.a_data;
  end

  assign w_a_illegal   = f_illegal(w_a_req);
  assign w_req_illegal = f_illegal(r_req);
  assign w_acc_error   = w_req_illegal || bus.reg_error;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_req      <= '0;
      r_a_ready  <= 1'b0;
      r_reg_we   <= 1'b0;
      r_reg_re   <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_opcode <= '0;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_error  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_a_ready <= 1'b1;
          if (bus.a_valid && r_a_ready) begin
            r_req     <= w_a_req;
            r_a_ready <= 1'b0;
            r_reg_we  <= f_is_put(w_a_req) && !w_a_illegal;
            r_reg_re  <= (w_a_req.opcode == OpGet) && !w_a_illegal;
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          r_reg_we   <= 1'b0;
          r_reg_re   <= 1'b0;
          r_d_valid  <= 1'b1;
          r_d_opcode <= (r_req.opcode == OpGet) ? OpAccessAckData : OpAccessAck;
          r_d_size   <= r_req.size;
          r_d_source <= r_req.source;
          r_d_error  <= w_acc_error;
          r_d_data   <= ((r_req.opcode == OpGet) && !w_acc_error) ? bus.reg_rdata : 32'h0;
          r_state    <= RESP;
        end
        RESP: begin
          if (bus.d_ready) begin
            r_d_valid <= 1'b0;
            r_a_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.a_ready   = r_a_ready;
  assign bus.d_valid   = r_d_valid;
  assign bus.d_opcode  = r_d_opcode;
  assign bus.d_size    = r_d_size;
  assign bus.d_source  = r_d_source;
  assign bus.d_data    = r_d_data;
  assign bus.d_error   = r_d_error;
  assign bus.reg_we    = r_reg_we;
  assign bus.reg_re    = r_reg_re;
  assign bus.reg_addr  = {r_req.address[AddrWidth-1:2], 2'b00};
  assign bus.reg_wdata = r_req.data;

endmodule

// File: doc/iopmp_tlul_reg_if.md
IOPMP_TLUL_REG_IF -- requirements
Module: iopmp_tlul_reg_if

Interface
REQ-001 SHALL provide parameter AddrWidth, default 12, register-space byte-address width.
REQ-002 SHALL provide parameter SourceWidth, default 8, TL-UL source-ID width.
REQ-003 SHALL provide `clk`, input, 1: single clock, all state updated on rising edge.
REQ-004 SHALL provide `rst`, input, 1: reset, synchronous, active-low.
REQ-005 SHALL provide TL-UL A-channel inputs: `a_valid` 1, `a_opcode` 3, `a_size` 2, `a_source` SourceWidth, `a_address` AddrWidth, `a_mask` 4, `a_data` 32, plus output `a_ready` 1.
REQ-006 SHALL provide TL-UL D-channel outputs: `d_valid` 1, `d_opcode` 3, `d_size` 2, `d_source` SourceWidth, `d_data` 32, `d_error` 1, plus input `d_ready` 1.
REQ-007 SHALL provide register-side outputs: `reg_we` 1 (write strobe), `reg_re` 1 (read strobe), `reg_addr` AddrWidth (word-aligned), `reg_wdata` 32.
REQ-008 SHALL provide register-side inputs: `reg_rdata` 32 (combinational read mux of register q values), `reg_error` 1 (address unmapped, or write to RO register).

Function
REQ-009 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, with one transaction outstanding at most.
REQ-010 SHALL drive `a_ready`=1 only in IDLE, and SHALL accept the request when `a_valid` && `a_ready`.
REQ-011 SHALL, on acceptance, latch opcode, size, source, address, mask and data, then go to ACCESS.
REQ-012 SHALL flag the request illegal when any of these holds: opcode not in {0 PutFull, 1 PutPartial, 4 Get}; `a_size` != 2; `a_address[1:0]` != 0; or a Put with `a_mask` != 4'hF (registers are full-word only).
REQ-013 SHALL, in ACCESS, pulse `reg_we` (Put) or `reg_re` (Get) for exactly one cycle, only for a legal request, with `reg_addr`/`reg_wdata` taken from the latched values.
REQ-014 SHALL, in ACCESS, capture `reg_rdata` (Get only) and `reg_error` into response registers, then go to RESP.
REQ-015 SHALL hold `reg_we` and `reg_re` at 0 in IDLE and RESP, and never assert both in the same cycle.
REQ-016 SHALL hold `d_valid`=1 throughout RESP, with fields stable until `d_valid` && `d_ready`, then go to IDLE.
REQ-017 SHALL set `d_opcode` to 1 (AccessAckData) for Get and 0 (AccessAck) otherwise, including for an illegal opcode.
REQ-018 SHALL echo the latched size and source on `d_size` and `d_source`.
REQ-019 SHALL set `d_error`=1 for an illegal request or a captured `reg_error`, and SHALL then force `d_data` to 32'h0.
REQ-020 SHALL, for a successful Get, drive `d_data` = captured `reg_rdata`; for a Put, drive `d_data` = 0.
REQ-021 SHALL give this latency: accept in cycle N, strobe in cycle N+1, `d_valid` first high in cycle N+2; the earliest next acceptance is the cycle after the D handshake.
REQ-022 SHALL, when `d_ready` is held low, stay in RESP indefinitely with `a_ready`=0 (backpressure).
REQ-023 SHALL ignore `a_*` inputs outside IDLE; a pending `a_valid` is not consumed.

Reset
REQ-024 SHALL, while `rst`=0 at a clock edge, go to IDLE and clear all outputs: `a_ready`=0, `d_valid`=0, `d_error`=0, `d_data`=0, `d_opcode`=0, `d_size`=0, `d_source`=0, `reg_we`=0, `reg_re`=0, `reg_addr`=0, `reg_wdata`=0.
REQ-025 SHALL, on reset asserted mid-transaction (ACCESS or RESP), drop the transaction with no strobe and no response emitted afterwards.
REQ-026 SHALL drive `a_ready`=1 from the first cycle after `rst` returns high.

Verification
REQ-027 SHALL cover: PutFull addr 0x010, data 0xDEADBEEF, mask F, source 5 -> `reg_we` one cycle at N+1 with `reg_addr`=0x010, `reg_wdata`=0xDEADBEEF; D at N+2 with opcode 0, source 5, error 0.
REQ-028 SHALL cover: Get addr 0x014 with `reg_rdata`=0x00000007 -> `reg_re` one cycle; D opcode 1, `d_data`=0x7, error 0.
REQ-029 SHALL cover: PutPartial mask 4'h3, and separately a Get at addr 0x012 -> no strobe; `d_error`=1, `d_data`=0.
REQ-030 SHALL cover: Get with `reg_error`=1 in ACCESS -> `d_error`=1, `d_opcode`=1, `d_data`=0.
REQ-031 SHALL cover: `d_ready` low for 5 cycles with back-to-back `a_valid` -> D fields stable, `a_ready`=0 throughout; second request accepted the cycle after the handshake.
REQ-032 SHALL cover: `rst`=0 asserted in RESP -> `d_valid`=0 next cycle, no further strobes; `a_ready`=1 the first cycle after release.
